dct_transpose_buf: RTL and testbench
====================================

Name: dct_transpose_buf

Overview:
Transpose buffer between the row-pass 1-D DCT (combinational, 8 signed 8-bit coefficients per 64-bit word) and the column-pass 1-D DCT. It accepts eight row words per 8x8 block and emits the same block as eight column words. Two ping-pong banks let one block fill while the previous block drains, so a continuous stream runs at one word per cycle.

Parameters:
N, 8, elements per row/column and rows/columns per block
ELEM_W, 8, bits per element (two's complement, passed through unmodified)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  in_row valid
in_ready  out  1  buffer can accept a row this cycle
in_row  in  N*ELEM_W  row word; element 0 in [63:56], element 7 in [7:0]
out_valid  out  1  out_col valid
out_ready  in  1  downstream accepts out_col this cycle
out_col  out  N*ELEM_W  column word; element from row 0 in [63:56], row 7 in [7:0]
out_first  out  1  out_col is column 0 of a block (qualified by out_valid)
out_last  out  1  out_col is column N-1 of a block (qualified by out_valid)

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Storage: two banks, each an NxN array of ELEM_W registers. Per-bank full flag. Write side holds wr_bank (1 bit) and wr_row (0..N-1). Read side holds rd_bank (1 bit) and rd_col (0..N-1).
- Reset: both full flags 0, wr_bank=rd_bank=0, wr_row=rd_col=0. This gives in_ready=1, out_valid=0, out_first=0, out_last=0. Array contents are not reset.
- Write transfer: a write happens on a rising edge when in_valid && in_ready. in_row is stored into bank[wr_bank] at row wr_row, and wr_row increments. When the transfer is at wr_row=N-1: full[wr_bank] is set, wr_row wraps to 0, and wr_bank toggles.
- in_ready = !full[wr_bank]. It is combinational from state only and does not depend on in_valid.
- Read side: out_valid = full[rd_bank].
  - out_col element r = bank[rd_bank][r][rd_col].
  - out_first = out_valid && rd_col==0.
  - out_last = out_valid && rd_col==N-1.
  - All of these are combinational from registered state. out_col is held stable while out_valid && !out_ready.
- Read transfer: a read happens on a rising edge when out_valid && out_ready. rd_col increments. When the transfer is at rd_col=N-1: full[rd_bank] is cleared, rd_col wraps to 0, and rd_bank toggles.
- Latency: the row N-1 write at edge k makes out_valid high in the cycle following edge k, for both banks. Column 0 is presented in that cycle.
- Throughput: sustained 1 row in / 1 column out per cycle when out_ready=1; no bubble between blocks.
- Simultaneous events:
  - The write setting full[x] and the read clearing full[y] on the same edge are both applied.
  - x==y cannot occur, because a bank is never written while full.
- Full: both banks full gives in_ready=0 until the next block's column N-1 is read. That read frees the bank on the same edge, so in_ready rises in the following cycle.
- Empty: out_valid=0. out_col is don't-care; the bench must not check it.
- Data: pure permutation, no arithmetic. Element bits, including sign, pass through bit-exact.
- Reset mid-block: any partially written or partially read block is discarded. Post-reset behaviour is identical to power-up.

Decomposition:
- Shared package:
  - constants N=8, ELEM_W=8, WORD_W=N*ELEM_W;
  - element typedef (signed ELEM_W);
  - row/column word typedef;
  - index typedef for 0..N-1.
- One natural sub-module, transpose_bank: the NxN register array with a row-write port (we, row index, word) and a combinational column-read port (column index -> word).
- The top level instantiates transpose_bank twice and holds the full flags and pointer control.

Test Plan:
- Single block, out_ready=1: rows r=0..7 with element c = 8'(r*16+c). Required outputs:
  - out_valid rises the cycle after row 7 is written.
  - Column c = {c, 16+c, 32+c, ..., 112+c} from MSB down.
  - out_first on column 0, out_last on column 7, then out_valid=0.
- Sign passthrough: all rows = 64'h80FF_7F01_8000_FF7F. Required: column 0 = 64'h8080_8080_8080_8080, column 7 = 64'h7F7F_7F7F_7F7F_7F7F.
- Streaming: 4 blocks back-to-back with in_valid=1 and out_ready=1 for 32 cycles. Required:
  - 32 columns out starting cycle 8, with no out_valid gap;
  - in_ready never drops;
  - each block is correctly transposed.
- Backpressure: out_ready=0, in_valid=1 continuously. Required:
  - in_ready drops after 16 rows accepted, and row 17 is held;
  - out_col stays stable at column 0 of block 0;
  - raising out_ready lets 8 columns drain, then in_ready=1 on the following cycle.
- Simultaneous boundary: row 7 of block 1 written on the same edge column 7 of block 0 is read. Required: the next cycle shows out_valid=1, out_first=1, rd_bank=1, in_ready=1.
- Reset mid-operation: assert rst_n=0 asynchronously after 5 rows of block 0. Required:
  - in_ready=1, out_valid=0 immediately;
  - after release, a fresh 8-row block transposes correctly and the discarded rows never appear.

Source files
------------

// File: rtl/dct_transpose_buf_pkg.sv
// Shared types and constants for the DCT transpose buffer.
// Holds the element, word and index types used by the top level and the bank,
// plus a helper that extracts one element from a packed word (element 0 at
// the most significant end).
package dct_transpose_buf_pkg;

    localparam int N      = 8;
    localparam int ELEM_W = 8;
    localparam int WORD_W = N * ELEM_W;

    typedef logic signed [ELEM_W-1:0] elem_t;
    typedef logic [WORD_W-1:0]        word_t;
    typedef logic [2:0]               idx_t;

    localparam idx_t IDX_LAST = 3'd7;

    // Element i of a packed word; element 0 occupies the top ELEM_W bits.
    function automatic elem_t word_elem(input word_t w, input idx_t i);
        return elem_t'(w[(WORD_W-1) - (int'(i) * ELEM_W) -: ELEM_W]);
    endfunction

endpackage

// File: rtl/dct_transpose_buf_transpose_bank.sv
// One NxN bank of the transpose buffer.
// Ports:
//   clk      - clock, writes on rising edge
//   we       - write enable for the row-write port
//   wr_row   - row index written when we=1
//   wr_word  - row word, element 0 in the top bits
//   rd_col   - column index for the combinational read port
//   rd_word  - column word, row 0 element in the top bits
// Contents are intentionally not reset: a bank is only read after all N rows
// of a block have been written into it.
module transpose_bank
    import dct_transpose_buf_pkg::*;
(
    input  logic  clk,
    input  logic  we,
    input  idx_t  wr_row,
    input  word_t wr_word,
    input  idx_t  rd_col,
    output word_t rd_word
);

    elem_t mem_r [N][N];

    // Row write: split the incoming word into its N elements.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int c = 0; c < N; c++) begin
                mem_r[wr_row][c] <= word_elem(wr_word, idx_t'(c));
            end
        end
    end

    // Column read: gather element rd_col of every row, row 0 at the top.
    always_comb begin
        rd_word = '0;
        for (int r = 0; r < N; r++) begin
            rd_word[(WORD_W-1) - (r * ELEM_W) -: ELEM_W] = mem_r[r][rd_col];
        end
    end

endmodule

// File: rtl/dct_transpose_buf.sv
// Ping-pong transpose buffer between the row-pass and column-pass 1-D DCT.
// Eight row words per 8x8 block go in; the same block comes out as eight
// column words. One bank fills while the other drains.
// Ports:
//   clk, rst_n           - clock and asynchronous active-low reset
//   in_valid/in_ready    - row handshake, in_row element 0 in [63:56]
//   out_valid/out_ready  - column handshake, out_col row 0 element in [63:56]
//   out_first/out_last   - column 0 / column N-1 of a block (with out_valid)
// Handshake outputs are decoded from registered state only, so in_ready never
// depends on in_valid and out_valid never depends on out_ready.
module dct_transpose_buf
    import dct_transpose_buf_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_row,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_col,
    output logic              out_first,
    output logic              out_last
);

    logic [1:0] full_r;
    logic [1:0] full_nxt_s;
    logic       wr_bank_r;
    logic       rd_bank_r;
    idx_t       wr_row_r;
    idx_t       rd_col_r;

    logic       wr_fire_s;
    logic       rd_fire_s;
    logic       wr_done_s;
    logic       rd_done_s;
    word_t      col0_s;
    word_t      col1_s;

    assign in_ready  = !full_r[wr_bank_r];
    assign out_valid = full_r[rd_bank_r];
    assign out_first = out_valid && (rd_col_r == 3'd0);
    assign out_last  = out_valid && (rd_col_r == IDX_LAST);
    assign out_col   = rd_bank_r ? col1_s : col0_s;

    assign wr_fire_s = in_valid && in_ready;
    assign rd_fire_s = out_valid && out_ready;
    assign wr_done_s = wr_fire_s && (wr_row_r == IDX_LAST);
    assign rd_done_s = rd_fire_s && (rd_col_r == IDX_LAST);

    transpose_bank u_bank0 (
        .clk     (clk),
        .we      (wr_fire_s && (wr_bank_r == 1'b0)),
        .wr_row  (wr_row_r),
        .wr_word (in_row),
        .rd_col  (rd_col_r),
        .rd_word (col0_s)
    );

    transpose_bank u_bank1 (
        .clk     (clk),
        .we      (wr_fire_s && (wr_bank_r == 1'b1)),
        .wr_row  (wr_row_r),
        .wr_word (in_row),
        .rd_col  (rd_col_r),
        .rd_word (col1_s)
    );

    // Full-flag update: a completed write sets its bank, a completed read
    // clears its bank; they never target the same bank on one edge because
    // a full bank is never written.
    always_comb begin
        full_nxt_s = full_r;
        if (wr_done_s) begin
            full_nxt_s[wr_bank_r] = 1'b1;
        end else begin
            full_nxt_s[wr_bank_r] = full_r[wr_bank_r];
        end
        if (rd_done_s) begin
            full_nxt_s[rd_bank_r] = 1'b0;
        end else begin
            full_nxt_s[rd_bank_r] = full_nxt_s[rd_bank_r];
        end
    end

    // Pointer and flag registers; 3-bit indices wrap from N-1 to 0 naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_r    <= 2'b00;
            wr_bank_r <= 1'b0;
            rd_bank_r <= 1'b0;
            wr_row_r  <= 3'd0;
            rd_col_r  <= 3'd0;
        end else begin
            full_r <= full_nxt_s;
            if (wr_fire_s) begin
                wr_row_r <= wr_row_r + 3'd1;
                if (wr_done_s) begin
                    wr_bank_r <= !wr_bank_r;
                end
            end
            if (rd_fire_s) begin
                rd_col_r <= rd_col_r + 3'd1;
                if (rd_done_s) begin
                    rd_bank_r <= !rd_bank_r;
                end
            end
        end
    end

endmodule

// File: tb/tb_dct_transpose_buf.sv
// Scoreboard bench for dct_transpose_buf: the stimulus pushes expected columns
// when a block completes, a negedge monitor pops and compares on every
// accepted output column.
module tb_dct_transpose_buf;

    typedef struct packed {
        logic [63:0] col;
        logic        first;
        logic        last;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_row;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_col;
    logic        out_first;
    logic        out_last;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e;

    dct_transpose_buf dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row    (in_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_col   (out_col),
        .out_first (out_first),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every accepted column must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_col got=%h (no column expected)", out_col);
            end else begin
                mon_e = sb.pop_front();
                if (out_col !== mon_e.col || out_first !== mon_e.first || out_last !== mon_e.last) begin
                    errors++;
                    $display("FAIL col_sb got=%h first=%0b last=%0b expected=%h first=%0b last=%0b",
                             out_col, out_first, out_last, mon_e.col, mon_e.first, mon_e.last);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Column c of a block given as eight row words.
    function automatic logic [63:0] tr_col(input logic [63:0] rows [8], input int c);
        logic [63:0] w;
        logic [63:0] rw;
        w = 64'd0;
        for (int r = 0; r < 8; r++) begin
            rw = rows[r];
            w[63 - 8*r -: 8] = rw[63 - 8*c -: 8];
        end
        return w;
    endfunction

    task automatic push_block(input logic [63:0] rows [8]);
        exp_t e;
        for (int c = 0; c < 8; c++) begin
            e.col   = tr_col(rows, c);
            e.first = (c == 0);
            e.last  = (c == 7);
            sb.push_back(e);
        end
    endtask

    // Offer one row and wait (bounded) until it is accepted; returns at edge+1.
    task automatic send_row(input logic [63:0] w);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_row   = w;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_row_timeout got=in_ready 0 expected=in_ready 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        out_ready = 1'b1;
        while (sb.size() > 0 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_empty_queue", 64'(sb.size()), 64'd0);
        chk("drain_out_valid", {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        logic [63:0] blk [8];
        logic [63:0] bp   [24];
        exp_t        e;
        int          acc;
        logic        rdy;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_row    = 64'd0;
        out_ready = 1'b0;
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        chk("reset_in_ready",  {63'd0, in_ready},  64'd1);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_out_first", {63'd0, out_first}, 64'd0);
        chk("reset_out_last",  {63'd0, out_last},  64'd0);

        // Single block: element c of row r = r*16+c
        out_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) blk[r][63 - 8*c -: 8] = 8'(r*16 + c);
        end
        for (int r = 0; r < 7; r++) send_row(blk[r]);
        chk("single_valid_before_row7", {63'd0, out_valid}, 64'd0);
        send_row(blk[7]);
        for (int c = 0; c < 8; c++) begin
            e.col = 64'd0;
            for (int r = 0; r < 8; r++) e.col[63 - 8*r -: 8] = 8'(16*r + c);
            e.first = (c == 0);
            e.last  = (c == 7);
            sb.push_back(e);
        end
        chk("single_valid_after_row7", {63'd0, out_valid}, 64'd1);
        chk("single_first_after_row7", {63'd0, out_first}, 64'd1);
        drain();

        // Sign passthrough
        for (int r = 0; r < 8; r++) begin
            blk[r] = 64'h80FF_7F01_8000_FF7F;
            send_row(blk[r]);
        end
        for (int c = 0; c < 8; c++) begin
            e.col   = (c == 0) ? 64'h8080_8080_8080_8080 :
                      (c == 7) ? 64'h7F7F_7F7F_7F7F_7F7F : tr_col(blk, c);
            e.first = (c == 0);
            e.last  = (c == 7);
            sb.push_back(e);
        end
        drain();

        // Streaming: 4 blocks back to back, 40-cycle window
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i < 32) begin
                for (int c = 0; c < 8; c++) in_row[63 - 8*c -: 8] = 8'((i/8)*64 + (i%8)*8 + c);
                in_valid = 1'b1;
                blk[i%8] = in_row;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (i < 32) chk("stream_in_ready", {63'd0, in_ready}, 64'd1);
            chk("stream_out_valid", {63'd0, out_valid}, {63'd0, (i >= 8)});
            if (i == 16) begin
                chk("boundary_out_first", {63'd0, out_first}, 64'd1);
                chk("boundary_rd_bank", {63'd0, dut.rd_bank_r}, 64'd1);
            end
            @(posedge clk);
            #1;
            if (i < 32 && (i % 8) == 7) push_block(blk);
        end
        in_valid = 1'b0;
        chk("stream_queue_empty", 64'(sb.size()), 64'd0);

        // Backpressure: out_ready low, rows offered continuously
        for (int i = 0; i < 24; i++) begin
            for (int c = 0; c < 8; c++) bp[i][63 - 8*c -: 8] = 8'(8'h11 * (i % 8) + 8'(c) + 8'(64 * (i / 8)));
        end
        for (int r = 0; r < 8; r++) blk[r] = bp[r];
        e.col = tr_col(blk, 0);
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 22; i++) begin
            in_valid = 1'b1;
            in_row   = bp[acc];
            @(negedge clk);
            rdy = in_ready;
            chk("bp_in_ready", {63'd0, in_ready}, {63'd0, (acc < 16)});
            if (acc >= 8) chk("bp_out_col_stable", out_col, e.col);
            @(posedge clk);
            #1;
            if (rdy) begin
                acc++;
                if ((acc % 8) == 0) begin
                    for (int r = 0; r < 8; r++) blk[r] = bp[acc - 8 + r];
                    push_block(blk);
                end
            end
        end
        chk("bp_rows_accepted", 64'(acc), 64'd16);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int j = 0; j < 9; j++) begin
            @(negedge clk);
            chk("bp_drain_in_ready", {63'd0, in_ready}, {63'd0, (j == 8)});
            @(posedge clk);
            #1;
        end
        for (int r = 16; r < 24; r++) send_row(bp[r]);
        for (int r = 0; r < 8; r++) blk[r] = bp[16 + r];
        push_block(blk);
        drain();

        // Reset mid-block after 5 rows
        for (int r = 0; r < 5; r++) send_row(64'hDEAD_BEEF_0000_0000 | 64'(r));
        #3;
        rst_n = 1'b0;
        #1;
        chk("midreset_in_ready",  {63'd0, in_ready},  64'd1);
        chk("midreset_out_valid", {63'd0, out_valid}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) blk[r][63 - 8*c -: 8] = 8'(8'hA0 + 8'(r*8 + c));
            send_row(blk[r]);
        end
        push_block(blk);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
